counter8_ctrl: RTL and testbench

COUNTER8_CTRL -- requirements
Module: counter8_ctrl

---
 rtl/counter8_ctrl_if.sv | 26 ++
 rtl/counter8_ctrl.sv | 148 ++++++++++++++
 tb/tb_counter8_ctrl.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/counter8_ctrl_if.sv
// Command/status bundle for counter8_ctrl: the controller side drives commands,
// the counter side returns the count, its seven-segment pattern and event pulses.
interface counter8_ctrl_if;
  logic       iStart;
  logic       iStop;
  logic       iStep;
  logic       iDir;
  logic       iMode;
  logic       iLoad;
  logic [2:0] iLoadVal;
  logic [2:0] oQ;
  logic [6:0] oDisplay;
  logic [1:0] oState;
  logic       oTick;
  logic       oDone;

  modport master (
    output iStart, iStop, iStep, iDir, iMode, iLoad, iLoadVal,
    input  oQ, oDisplay, oState, oTick, oDone
  );

  modport slave (
    input  iStart, iStop, iStep, iDir, iMode, iLoad, iLoadVal,
    output oQ, oDisplay, oState, oTick, oDone
  );
endinterface

// File: rtl/counter8_ctrl.sv
// 3-bit up/down counter advanced by a DIV-cycle prescaler, with run/pause/step,
// one-shot mode, synchronous load and an active-low seven-segment readout.
module counter8_ctrl #(
  parameter int DIV = 4
) (
  input  logic             CLK,
  input  logic             rst_n,
  counter8_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  localparam logic [15:0] PRESC_LAST = 16'(DIV - 1);

  state_e      state_q, state_d;
  logic [2:0]  q_q, q_d;
  logic [15:0] presc_q, presc_d;
  logic        tick_q, tick_d;
  logic        done_q, done_d;

  logic [2:0]  terminal;
  logic [2:0]  q_adv;
  logic        at_term;
  logic        presc_hit;
  logic        ev_load;
  logic        ev_stop;
  logic        ev_start;
  logic        ev_step;

  function automatic logic [6:0] seg7(input logic [2:0] v);
    logic [6:0] s;
    unique case (v)
      3'd0: s = 7'b1000000;
      3'd1: s = 7'b1111001;
      3'd2: s = 7'b0100100;
      3'd3: s = 7'b0110000;
      3'd4: s = 7'b0011001;
      3'd5: s = 7'b0010010;
      3'd6: s = 7'b0000010;
      3'd7: s = 7'b1111000;
    endcase
    return s;
  endfunction

  // Only the highest-priority asserted command is allowed to act.
  always_comb begin
    terminal  = bus.iDir ? 3'd0 : 3'd7;
    at_term   = bus.iMode && (q_q == terminal);
    q_adv     = bus.iDir ? (q_q - 3'd1) : (q_q + 3'd1);
    presc_hit = (presc_q == PRESC_LAST);
    ev_load   = bus.iLoad;
    ev_stop   = !bus.iLoad && bus.iStop;
    ev_start  = !bus.iLoad && !bus.iStop && bus.iStart;
    ev_step   = !bus.iLoad && !bus.iStop && !bus.iStart && bus.iStep;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      q_q     <= 3'd0;
      presc_q <= 16'd0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (ev_load) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  if (ev_start) state_d = S_RUN;
        S_RUN: begin
          if (ev_stop)                   state_d = S_PAUSE;
          else if (presc_hit && at_term) state_d = S_DONE;
        end
        S_PAUSE: if (ev_start) state_d = S_RUN;
        S_DONE:  if (ev_start) state_d = S_RUN;
      endcase
    end
  end

  // Count, prescaler and event pulses; a stop in RUN freezes the prescaler.
  always_comb begin
    q_d     = q_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;
    if (ev_load) begin
      q_d     = bus.iLoadVal;
      presc_d = 16'd0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (ev_start) presc_d = 16'd0;
        end
        S_RUN: begin
          if (!ev_stop) begin
            if (presc_hit) begin
              presc_d = 16'd0;
              if (at_term) begin
                done_d = 1'b1;
              end else begin
                q_d    = q_adv;
                tick_d = 1'b1;
              end
            end else begin
              presc_d = presc_q + 16'd1;
            end
          end
        end
        S_PAUSE: begin
          if (ev_step && !at_term) begin
            q_d    = q_adv;
            tick_d = 1'b1;
          end
        end
        S_DONE: begin
          if (ev_start) begin
            q_d     = bus.iDir ? 3'd7 : 3'd0;
            presc_d = 16'd0;
          end
        end
      endcase
    end
  end

  always_comb begin
    bus.oQ       = q_q;
    bus.oDisplay = seg7(q_q);
    bus.oState   = state_q;
    bus.oTick    = tick_q;
    bus.oDone    = done_q;
  end

endmodule

// File: tb/tb_counter8_ctrl.sv
// Directed bench for counter8_ctrl (DIV=4): stimulus queues expected pulses,
// a negedge monitor pops and compares each oTick/oDone event.
module tb_counter8_ctrl;

  logic CLK = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  localparam logic [1:0] ST_IDLE = 2'b00, ST_RUN = 2'b01, ST_PAUSE = 2'b10, ST_DONE = 2'b11;

  counter8_ctrl_if cif();

  counter8_ctrl #(.DIV(4)) dut (
    .CLK  (CLK),
    .rst_n(rst_n),
    .bus  (cif)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       tick;
    logic       done;
    logic [2:0] q;
    logic [1:0] st;
  } ev_t;

  ev_t sbq[$];

  logic [6:0] seg_ref [8] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic t, input logic d, input logic [2:0] q, input logic [1:0] st);
    ev_t e;
    e.tick = t; e.done = d; e.q = q; e.st = st;
    sbq.push_back(e);
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic chk_state(input string name, input logic [1:0] st, input logic [2:0] q);
    chk({name, "_state"}, cif.oState, st);
    chk({name, "_q"}, cif.oQ, q);
    chk({name, "_disp"}, cif.oDisplay, seg_ref[q]);
  endtask

  // Monitor: every pulse must match the next queued expectation.
  always @(negedge CLK) begin : monitor
    ev_t e;
    if (rst_n === 1'b1 && (cif.oTick === 1'b1 || cif.oDone === 1'b1)) begin
      chk("tick_done_exclusive", cif.oTick & cif.oDone, 1'b0);
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse actual tick=%0b done=%0b q=%0d state=%0d required none (t=%0t)",
                 cif.oTick, cif.oDone, cif.oQ, cif.oState, $time);
      end else begin
        e = sbq.pop_front();
        chk("pulse_tick", cif.oTick, e.tick);
        chk("pulse_done", cif.oDone, e.done);
        chk("pulse_q", cif.oQ, e.q);
        chk("pulse_state", cif.oState, e.st);
        chk("pulse_disp", cif.oDisplay, seg_ref[e.q]);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timed out");
  end

  initial begin : stim
    rst_n        = 1'b1;
    cif.iStart   = 1'b0;
    cif.iStop    = 1'b0;
    cif.iStep    = 1'b0;
    cif.iDir     = 1'b0;
    cif.iMode    = 1'b0;
    cif.iLoad    = 1'b0;
    cif.iLoadVal = 3'd0;
    cycles(2);

    // Asynchronous reset, checked before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk_state("reset", ST_IDLE, 3'd0);
    chk("reset_tick", cif.oTick, 1'b0);
    chk("reset_done", cif.oDone, 1'b0);
    cycles(2);

    // Start present on the first edge after release; continuous up count.
    cif.iStart = 1'b1;
    rst_n = 1'b1;
    for (int v = 1; v <= 8; v++) push(1'b1, 1'b0, 3'(v), ST_RUN);
    cyc();
    cif.iStart = 1'b0;
    chk_state("start", ST_RUN, 3'd0);
    cycles(3);
    chk("pre_first_tick", cif.oTick, 1'b0);
    chk_state("pre_first_tick", ST_RUN, 3'd0);
    cyc();
    chk("first_tick", cif.oTick, 1'b1);
    chk_state("first_tick", ST_RUN, 3'd1);
    cycles(28);
    chk_state("wrap", ST_RUN, 3'd0);

    // Pause with prescaler=2, step three times, resume.
    cycles(2);
    cif.iStop = 1'b1;
    cyc();
    cif.iStop = 1'b0;
    chk_state("pause", ST_PAUSE, 3'd0);
    cycles(3);
    chk_state("pause_hold", ST_PAUSE, 3'd0);
    for (int v = 1; v <= 3; v++) push(1'b1, 1'b0, 3'(v), ST_PAUSE);
    cif.iStep = 1'b1;
    cycles(3);
    cif.iStep = 1'b0;
    chk_state("steps", ST_PAUSE, 3'd3);
    push(1'b1, 1'b0, 3'd4, ST_RUN);
    cif.iStart = 1'b1;
    cyc();
    cif.iStart = 1'b0;
    chk_state("resume", ST_RUN, 3'd3);
    cyc();
    chk("resume_notick", cif.oTick, 1'b0);
    cyc();
    chk("resume_tick", cif.oTick, 1'b1);
    chk_state("resume_tick", ST_RUN, 3'd4);

    // Load beats stop and start in the same cycle.
    cyc();
    cif.iLoad = 1'b1; cif.iLoadVal = 3'd6; cif.iStop = 1'b1; cif.iStart = 1'b1;
    cyc();
    cif.iLoad = 1'b0; cif.iStop = 1'b0; cif.iStart = 1'b0;
    chk_state("load_wins", ST_IDLE, 3'd6);
    chk("load_notick", cif.oTick, 1'b0);
    cycles(8);
    chk_state("load_idle", ST_IDLE, 3'd6);

    // One-shot down count from 2 to DONE, then restart at 7.
    cif.iMode = 1'b1; cif.iDir = 1'b1;
    cif.iLoad = 1'b1; cif.iLoadVal = 3'd2;
    cyc();
    cif.iLoad = 1'b0;
    chk_state("load2", ST_IDLE, 3'd2);
    push(1'b1, 1'b0, 3'd1, ST_RUN);
    push(1'b1, 1'b0, 3'd0, ST_RUN);
    push(1'b0, 1'b1, 3'd0, ST_DONE);
    cif.iStart = 1'b1;
    cyc();
    cif.iStart = 1'b0;
    cycles(11);
    chk_state("pre_done", ST_RUN, 3'd0);
    cyc();
    chk_state("done", ST_DONE, 3'd0);
    chk("done_pulse", cif.oDone, 1'b1);
    chk("done_notick", cif.oTick, 1'b0);
    cif.iStep = 1'b1; cif.iStop = 1'b1;
    cycles(3);
    cif.iStep = 1'b0; cif.iStop = 1'b0;
    chk_state("done_ignore", ST_DONE, 3'd0);
    chk("done_once", cif.oDone, 1'b0);

    // Restart down from 7, switch to up at 3, finish at 7.
    for (int v = 6; v >= 3; v--) push(1'b1, 1'b0, 3'(v), ST_RUN);
    for (int v = 4; v <= 7; v++) push(1'b1, 1'b0, 3'(v), ST_RUN);
    push(1'b0, 1'b1, 3'd7, ST_DONE);
    cif.iStart = 1'b1;
    cyc();
    cif.iStart = 1'b0;
    chk_state("restart", ST_RUN, 3'd7);
    cycles(16);
    chk_state("at3", ST_RUN, 3'd3);
    cif.iDir = 1'b0;
    cycles(4);
    chk_state("dir_flip", ST_RUN, 3'd4);
    cycles(12);
    chk_state("up_to7", ST_RUN, 3'd7);
    cycles(4);
    chk_state("done_up", ST_DONE, 3'd7);

    // One-shot step at terminal is blocked; continuous steps wrap.
    cif.iLoad = 1'b1; cif.iLoadVal = 3'd7;
    cyc();
    cif.iLoad = 1'b0;
    cif.iStart = 1'b1;
    cyc();
    cif.iStart = 1'b0;
    cyc();
    cif.iStop = 1'b1;
    cyc();
    cif.iStop = 1'b0;
    chk_state("pause7", ST_PAUSE, 3'd7);
    cif.iStep = 1'b1;
    cycles(2);
    cif.iStep = 1'b0;
    chk_state("step_blocked", ST_PAUSE, 3'd7);
    cif.iMode = 1'b0;
    push(1'b1, 1'b0, 3'd0, ST_PAUSE);
    cif.iStep = 1'b1;
    cyc();
    cif.iStep = 1'b0;
    chk_state("step_wrap_up", ST_PAUSE, 3'd0);
    cif.iDir = 1'b1;
    push(1'b1, 1'b0, 3'd7, ST_PAUSE);
    cif.iStep = 1'b1;
    cyc();
    cif.iStep = 1'b0;
    chk_state("step_wrap_dn", ST_PAUSE, 3'd7);

    // Short reset pulse between edges while running at 5.
    cif.iDir = 1'b0;
    cif.iLoad = 1'b1; cif.iLoadVal = 3'd4;
    cyc();
    cif.iLoad = 1'b0;
    push(1'b1, 1'b0, 3'd5, ST_RUN);
    cif.iStart = 1'b1;
    cyc();
    cif.iStart = 1'b0;
    cycles(4);
    chk_state("run5", ST_RUN, 3'd5);
    cyc();
    #1 rst_n = 1'b0;
    #1;
    chk_state("midrun_reset", ST_IDLE, 3'd0);
    chk("midrun_reset_tick", cif.oTick, 1'b0);
    #2 rst_n = 1'b1;
    cycles(10);
    chk_state("post_reset_idle", ST_IDLE, 3'd0);

    // Start held through reset release is honoured on the first edge.
    #1 rst_n = 1'b0;
    cif.iStart = 1'b1;
    #2 rst_n = 1'b1;
    push(1'b1, 1'b0, 3'd1, ST_RUN);
    cyc();
    cif.iStart = 1'b0;
    chk_state("start_after_reset", ST_RUN, 3'd0);
    cycles(4);
    chk_state("tick_after_reset", ST_RUN, 3'd1);

    cycles(2);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
